// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage.
// - ALU operation codes carried on ID_ALUOp
// - Multiply/divide FSM state encoding
// - Default datapath width
package ex_pkg;

  localparam int unsigned DefaultDataW = 32;

  localparam logic [4:0] AluAdd   = 5'd0;
  localparam logic [4:0] AluSub   = 5'd1;
  localparam logic [4:0] AluAnd   = 5'd2;
  localparam logic [4:0] AluOr    = 5'd3;
  localparam logic [4:0] AluXor   = 5'd4;
  localparam logic [4:0] AluNor   = 5'd5;
  localparam logic [4:0] AluSlt   = 5'd6;
  localparam logic [4:0] AluSltu  = 5'd7;
  localparam logic [4:0] AluSll   = 5'd8;
  localparam logic [4:0] AluSrl   = 5'd9;
  localparam logic [4:0] AluSra   = 5'd10;
  localparam logic [4:0] AluLui   = 5'd11;
  localparam logic [4:0] AluMult  = 5'd12;
  localparam logic [4:0] AluMultu = 5'd13;
  localparam logic [4:0] AluDiv   = 5'd14;
  localparam logic [4:0] AluDivu  = 5'd15;
  localparam logic [4:0] AluMfhi  = 5'd16;
  localparam logic [4:0] AluMflo  = 5'd17;

  typedef enum logic [0:0] {
    MdIdle,
    MdBusy
  } md_state_e;

  // MULT/MULTU/DIV/DIVU
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= AluMult) && (op <= AluDivu);
  endfunction

  // MFHI/MFLO
  function automatic logic is_hilo_read(input logic [4:0] op);
    return (op == AluMfhi) || (op == AluMflo);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage.
// master: decode side (drives ID_*, observes EX_*).
// slave : execute stage (observes ID_*, drives EX_*).
interface ex_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  ID_Valid;
  logic [4:0]            ID_ALUOp;
  logic [DATA_W-1:0]     ID_OpA;
  logic [DATA_W-1:0]     ID_OpB;
  logic [4:0]            ID_Shamt;
  logic [1:0]            ID_WB;
  logic [1:0]            ID_M;
  logic [DATA_W-1:0]     ID_StoreData;
  logic [REG_ADDR_W-1:0] ID_WriteReg;

  logic                  EX_Stall;
  logic                  EX_Valid;
  logic [1:0]            EX_WB;
  logic [1:0]            EX_M;
  logic [DATA_W-1:0]     EX_ALUResult;
  logic [DATA_W-1:0]     EX_StoreData;
  logic                  EX_RegWrite;
  logic [REG_ADDR_W-1:0] EX_WriteReg;
  logic [DATA_W-1:0]     EX_WriteData;

  modport master (
    output ID_Valid, ID_ALUOp, ID_OpA, ID_OpB, ID_Shamt, ID_WB, ID_M, ID_StoreData, ID_WriteReg,
    input  EX_Stall, EX_Valid, EX_WB, EX_M, EX_ALUResult, EX_StoreData, EX_RegWrite,
           EX_WriteReg, EX_WriteData
  );

  modport slave (
    input  ID_Valid, ID_ALUOp, ID_OpA, ID_OpB, ID_Shamt, ID_WB, ID_M, ID_StoreData, ID_WriteReg,
    output EX_Stall, EX_Valid, EX_WB, EX_M, EX_ALUResult, EX_StoreData, EX_RegWrite,
           EX_WriteReg, EX_WriteData
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO.
// Ports: clk_i, rst_ni (async active-low), start_i (accept op_i/a_i/b_i),
//        busy_o (iterating), hi_o/lo_o (architectural HI/LO).
// One operation takes DATA_W iterations; HI/LO update on the last one.
module muldiv_unit import ex_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [4:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dbz_q, dbz_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] a_raw_q, a_raw_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic                sgn_op, div_op;
  logic [DATA_W-1:0]   mul_add;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_tmp;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] prod;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sgn_op    = (op_i == AluMult) || (op_i == AluDiv);
    div_op    = (op_i == AluDiv) || (op_i == AluDivu);
    mul_add   = '0;
    mul_sum   = '0;
    div_tmp   = '0;
    div_diff  = '0;
    prod      = '0;

    case (state_q)
      MdIdle: begin
        if (start_i) begin
          state_d   = MdBusy;
          cnt_d     = '0;
          is_div_d  = div_op;
          // Work on magnitudes; signs are restored when the result is written.
          acc_hi_d  = '0;
          acc_lo_d  = mag(a_i, sgn_op);
          opb_d     = mag(b_i, sgn_op);
          neg_res_d = sgn_op && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
          neg_rem_d = sgn_op && a_i[DATA_W-1];
          dbz_d     = div_op && (b_i == '0);
          a_raw_d   = a_i;
        end
      end
      MdBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          // Restoring step: shift next dividend bit into the partial remainder.
          div_tmp  = {acc_hi_q, acc_lo_q[DATA_W-1]};
          div_diff = {1'b0, div_tmp} - {2'b00, opb_q};
          if (!div_diff[DATA_W+1]) begin
            acc_hi_d = div_diff[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_hi_d = div_tmp[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          // Shift-add: multiplier bits consumed from acc_lo LSB, product shifts in at top.
          mul_add  = acc_lo_q[0] ? opb_q : '0;
          mul_sum  = {1'b0, acc_hi_q} + {1'b0, mul_add};
          acc_hi_d = mul_sum[DATA_W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end

        if (cnt_q == LastCnt) begin
          state_d = MdIdle;
          cnt_d   = '0;
          if (is_div_q) begin
            if (dbz_q) begin
              lo_d = '1;
              hi_d = a_raw_q;
            end else begin
              lo_d = neg_res_q ? -acc_lo_d : acc_lo_d;
              hi_d = neg_rem_q ? -acc_hi_d : acc_hi_d;
            end
          end else begin
            prod = {acc_hi_d, acc_lo_d};
            if (neg_res_q) prod = -prod;
            hi_d = prod[2*DATA_W-1:DATA_W];
            lo_d = prod[DATA_W-1:0];
          end
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MdIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (state_q == MdBusy);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU/shifter, iterative MUL/DIV (muldiv_unit),
// HI/LO hazard stall and the EX/MEM pipeline register.
// Ports: Clk, Rst_n (async active-low), bus (ex_stage_if.slave: ID_* in, EX_* out).
module ex_stage import ex_pkg::*; #(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic       Clk,
  input logic       Rst_n,
  ex_stage_if.slave bus
);

  logic [4:0]        op;
  logic [DATA_W-1:0] opa, opb;
  logic              md_busy, md_start, stall, issue, rw_ok;
  logic [DATA_W-1:0] md_hi, md_lo, alu_res;

  logic                  valid_q, valid_d;
  logic [1:0]            wb_q, wb_d;
  logic [1:0]            m_q, m_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic [DATA_W-1:0]     sd_q, sd_d;
  logic [REG_ADDR_W-1:0] wr_q, wr_d;

  assign op  = bus.ID_ALUOp;
  assign opa = bus.ID_OpA;
  assign opb = bus.ID_OpB;

  // Only instructions touching HI/LO wait for the unit; everything else flows past it.
  assign stall    = md_busy && bus.ID_Valid && (is_muldiv(op) || is_hilo_read(op));
  assign issue    = bus.ID_Valid && !stall;
  assign md_start = issue && is_muldiv(op);
  assign rw_ok    = (op <= AluLui) || is_hilo_read(op);

  muldiv_unit #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .start_i (md_start),
    .op_i    (op),
    .a_i     (opa),
    .b_i     (opb),
    .busy_o  (md_busy),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      AluAdd:  alu_res = opa + opb;
      AluSub:  alu_res = opa - opb;
      AluAnd:  alu_res = opa & opb;
      AluOr:   alu_res = opa | opb;
      AluXor:  alu_res = opa ^ opb;
      AluNor:  alu_res = ~(opa | opb);
      AluSlt:  alu_res = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(opb)};
      AluSltu: alu_res = {{(DATA_W-1){1'b0}}, opa < opb};
      AluSll:  alu_res = opb << bus.ID_Shamt;
      AluSrl:  alu_res = opb >> bus.ID_Shamt;
      AluSra:  alu_res = $unsigned($signed(opb) >>> bus.ID_Shamt);
      AluLui:  alu_res = {opb[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      AluMfhi: alu_res = md_hi;
      AluMflo: alu_res = md_lo;
      default: alu_res = '0;
    endcase
  end

  // Stalled or empty slots load an all-zero bubble.
  always_comb begin
    valid_d = 1'b0;
    wb_d    = 2'b00;
    m_d     = 2'b00;
    res_d   = '0;
    sd_d    = '0;
    wr_d    = '0;
    if (issue) begin
      valid_d = 1'b1;
      wb_d    = {bus.ID_WB[1] && rw_ok, bus.ID_WB[0]};
      m_d     = bus.ID_M;
      res_d   = alu_res;
      sd_d    = bus.ID_StoreData;
      wr_d    = bus.ID_WriteReg;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      wb_q    <= 2'b00;
      m_q     <= 2'b00;
      res_q   <= '0;
      sd_q    <= '0;
      wr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      m_q     <= m_d;
      res_q   <= res_d;
      sd_q    <= sd_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.EX_Stall     = stall;
  assign bus.EX_Valid     = valid_q;
  assign bus.EX_WB        = wb_q;
  assign bus.EX_M         = m_q;
  assign bus.EX_ALUResult = res_q;
  assign bus.EX_StoreData = sd_q;
  assign bus.EX_RegWrite  = valid_q && wb_q[1];
  assign bus.EX_WriteReg  = wr_q;
  assign bus.EX_WriteData = res_q;

endmodule
